// File: rtl/alu_sequencer.sv
// Execute-stage sequencer wrapping an external combinational RV64I ALU (X operand stage, R result stage).
// Latency: op accepted at edge N presents res_valid_o after edge N+1; sustains 1 op/cycle.
// Backpressure: R holds while res_valid_o && !res_ready_i; op_ready_o drops only when X is also occupied.
module alu_sequencer #(
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            flush_i,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic            alt_i,
  input  logic            imm_i,
  input  logic            word_i,
  input  logic [63:0]     rs1_i,
  input  logic [63:0]     rs2_i,
  input  logic [RD_W-1:0] rd_i,
  output logic [63:0]     alu_a_o,
  output logic [63:0]     alu_b_o,
  output logic            alu_c_o,
  output logic            alu_sum_o,
  output logic            alu_and_o,
  output logic            alu_xor_o,
  output logic            alu_invb_o,
  output logic            alu_lsh_o,
  output logic            alu_rsh_o,
  output logic            alu_ltu_o,
  output logic            alu_lts_o,
  input  logic [63:0]     alu_out_i,
  input  logic            alu_c_i,
  input  logic            alu_v_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [63:0]     res_data_o,
  output logic [RD_W-1:0] res_rd_o,
  output logic            res_illegal_o
);

  typedef struct packed {
    logic sum;
    logic andf;
    logic xorf;
    logic invb;
    logic lsh;
    logic rsh;
  } alu_en_t;

  // X stage
  logic            x_valid_q;
  logic [63:0]     a_q, a_d, b_q, b_d;
  logic            c_q, c_d;
  alu_en_t         en_q, en_d;
  logic [2:0]      f3_q;
  logic            word_q;
  logic            ill_q, ill_d;
  logic [RD_W-1:0] rd_q;

  // R stage
  logic            res_valid_q;
  logic [63:0]     res_data_q, res_data_d;
  logic [RD_W-1:0] res_rd_q;
  logic            res_ill_q;

  logic r_free, x_adv, accept;

  assign r_free     = !res_valid_q || res_ready_i;
  assign x_adv      = x_valid_q && r_free;
  // Gated by reset so every output reads 0 while reset is asserted.
  assign op_ready_o = reset_ni && (!x_valid_q || r_free);
  assign accept     = op_valid_i && op_ready_o;

  // Decode incoming op into ALU operands/controls; W forms adjust operands or flag illegal.
  always_comb begin
    a_d   = rs1_i;
    b_d   = rs2_i;
    c_d   = 1'b0;
    en_d  = '0;
    ill_d = 1'b0;
    case (funct3_i)
      3'b000: begin
        en_d.sum = 1'b1;
        if (alt_i && !imm_i) begin
          en_d.invb = 1'b1;
          c_d       = 1'b1;
        end
      end
      3'b001: en_d.lsh = 1'b1;
      3'b010, 3'b011: begin
        en_d.sum  = 1'b1;
        en_d.invb = 1'b1;
        c_d       = 1'b1;
      end
      3'b100: en_d.xorf = 1'b1;
      3'b101: begin
        en_d.rsh = 1'b1;
        c_d      = alt_i;
      end
      3'b110: begin
        // AND and XOR together: the ALU ORs unit outputs, (A&B)|(A^B) = A|B.
        en_d.andf = 1'b1;
        en_d.xorf = 1'b1;
      end
      default: en_d.andf = 1'b1;
    endcase
    if (word_i) begin
      case (funct3_i)
        3'b000: begin
          ill_d = 1'b0;
        end
        3'b001: b_d[5] = 1'b0;
        3'b101: begin
          b_d[5] = 1'b0;
          a_d    = alt_i ? {{32{rs1_i[31]}}, rs1_i[31:0]} : {32'b0, rs1_i[31:0]};
        end
        default: begin
          en_d  = '0;
          c_d   = 1'b0;
          ill_d = 1'b1;
        end
      endcase
    end
  end

  // Post-process ALU output: compare results from flags, W sign-extension, illegal forces 0.
  always_comb begin
    res_data_d = alu_out_i;
    if (ill_q) begin
      res_data_d = '0;
    end else if (word_q) begin
      res_data_d = {{32{alu_out_i[31]}}, alu_out_i[31:0]};
    end else if (f3_q == 3'b010) begin
      res_data_d = {63'b0, alu_out_i[63] ^ alu_v_i};
    end else if (f3_q == 3'b011) begin
      res_data_d = {63'b0, ~alu_c_i};
    end
  end

  // X stage register: load on accept, empty when its op moves to R; flush wins.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_valid_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      en_q      <= '0;
      f3_q      <= '0;
      word_q    <= 1'b0;
      ill_q     <= 1'b0;
      rd_q      <= '0;
    end else if (flush_i) begin
      x_valid_q <= 1'b0;
    end else if (accept) begin
      x_valid_q <= 1'b1;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      en_q      <= en_d;
      f3_q      <= funct3_i;
      word_q    <= word_i;
      ill_q     <= ill_d;
      rd_q      <= rd_i;
    end else if (x_adv) begin
      x_valid_q <= 1'b0;
    end
  end

  // R stage register: capture on x_adv, clear when drained, hold while stalled.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_ill_q   <= 1'b0;
    end else if (flush_i) begin
      res_valid_q <= 1'b0;
    end else if (x_adv) begin
      res_valid_q <= 1'b1;
      res_data_q  <= res_data_d;
      res_rd_q    <= rd_q;
      res_ill_q   <= ill_q;
    end else if (res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_c_o       = c_q;
  assign alu_sum_o     = x_valid_q && en_q.sum;
  assign alu_and_o     = x_valid_q && en_q.andf;
  assign alu_xor_o     = x_valid_q && en_q.xorf;
  assign alu_invb_o    = x_valid_q && en_q.invb;
  assign alu_lsh_o     = x_valid_q && en_q.lsh;
  assign alu_rsh_o     = x_valid_q && en_q.rsh;
  assign alu_ltu_o     = 1'b0;
  assign alu_lts_o     = 1'b0;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_rd_o      = res_rd_q;
  assign res_illegal_o = res_ill_q;

endmodule
